ifetch: RTL and testbench



---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch_if.sv | 31 +++
 rtl/ifetch_fifo.sv | 90 +++++++++
 rtl/ifetch.sv | 74 +++++++
 tb/tb_ifetch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch-stage parameters and the occupancy rule that decides whether a new
// memory read may be issued without overrunning the 2-entry instruction buffer.
package ifetch_pkg;

  localparam int WORD_W       = 32;
  localparam int ADDR_W       = 16;
  localparam int RESET_PC_DEF = 0;
  localparam int FIFO_DEPTH   = 2;

  typedef logic [1:0] cnt_t;

  // Buffered + outstanding entries after this cycle's pop must leave room for the new read.
  function automatic logic can_issue(input cnt_t count, input logic inflight_v, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, inflight_v} - {2'b00, pop};
    return occ < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory read port, decode-facing valid/stall output and
// the redirect input from execute.
interface ifetch_if #(
  parameter int WORD = 32,
  parameter int ADDR = 16
);

  logic            imem_req_o;
  logic [ADDR-1:0] imem_addr_o;
  logic [WORD-1:0] imem_data_i;
  logic            v_o;
  logic [WORD-1:0] inst_o;
  logic [ADDR-1:0] origaddr_o;
  logic            stall_i;
  logic            br_v_i;
  logic [ADDR-1:0] br_addr_i;

  // Handshake: an instruction transfers to decode in a cycle where v_o=1, stall_i=0 and
  // br_v_i=0; while stalled, v_o/inst_o/origaddr_o hold. The memory is always ready and
  // returns imem_data_i exactly one cycle after imem_req_o.
  modport master (
    output imem_req_o, imem_addr_o, v_o, inst_o, origaddr_o,
    input  imem_data_i, stall_i, br_v_i, br_addr_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, v_o, inst_o, origaddr_o,
    output imem_data_i, stall_i, br_v_i, br_addr_i
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Two-entry {inst, addr} queue between the memory response and decode. Slot 0 is
// always the head; flush empties it and wins over push and pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WORD = WORD_W,
  parameter int ADDR = ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [WORD-1:0] push_inst_i,
  input  logic [ADDR-1:0] push_addr_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output cnt_t            count_o,
  output logic [WORD-1:0] head_inst_o,
  output logic [ADDR-1:0] head_addr_o
);

  logic [WORD-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic [ADDR-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  cnt_t            count_q, count_d;

  always_comb begin
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            inst0_d = push_inst_i;
            addr0_d = push_addr_i;
          end else begin
            inst1_d = push_inst_i;
            addr1_d = push_addr_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          inst0_d = inst1_q;
          addr0_d = addr1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands right behind whatever remains.
          if (count_q == 2'd1) begin
            inst0_d = push_inst_i;
            addr0_d = push_addr_i;
          end else begin
            inst0_d = inst1_q;
            addr0_d = addr1_q;
            inst1_d = push_inst_i;
            addr1_d = push_addr_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst0_q <= '0;
      inst1_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      count_q <= '0;
    end else begin
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_inst_o = inst0_q;
  assign head_addr_o = addr0_q;

  no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && !pop_i && count_q == 2'd2));

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the word-addressed PC, keeps at most one read outstanding to a
// one-cycle instruction memory, and buffers responses for decode. A redirect flushes all.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int              WORD     = WORD_W,
  parameter int              ADDR     = ADDR_W,
  parameter logic [ADDR-1:0] RESET_PC = ADDR'(RESET_PC_DEF)
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  logic [ADDR-1:0] pc_q, pc_d;
  logic [ADDR-1:0] inflight_addr_q, inflight_addr_d;
  logic            inflight_v_q, inflight_v_d;
  cnt_t            count;
  logic            pop, push, issue;
  logic [WORD-1:0] head_inst;
  logic [ADDR-1:0] head_addr;

  always_comb begin
    pop   = (count != 2'd0) & ~bus.stall_i & ~bus.br_v_i;
    push  = inflight_v_q & ~bus.br_v_i;
    // Gating by rst keeps the request low while reset is held, not just after the edge.
    issue = ~rst & ~bus.br_v_i & can_issue(count, inflight_v_q, pop);

    pc_d            = pc_q;
    inflight_addr_d = inflight_addr_q;
    inflight_v_d    = issue;
    if (bus.br_v_i) begin
      pc_d = bus.br_addr_i;
    end else if (issue) begin
      pc_d            = pc_q + ADDR'(1);
      inflight_addr_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      inflight_addr_q <= '0;
      inflight_v_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      inflight_addr_q <= inflight_addr_d;
      inflight_v_q    <= inflight_v_d;
    end
  end

  ifetch_fifo #(
    .WORD(WORD),
    .ADDR(ADDR)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_inst_i(bus.imem_data_i),
    .push_addr_i(inflight_addr_q),
    .pop_i      (pop),
    .flush_i    (bus.br_v_i),
    .count_o    (count),
    .head_inst_o(head_inst),
    .head_addr_o(head_addr)
  );

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc_q;
  assign bus.v_o         = (count != 2'd0);
  assign bus.inst_o      = head_inst;
  assign bus.origaddr_o  = head_addr;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: hand-derived vector table, a reset-mid-stream sequence, then random
// stall/redirect/reset traffic checked against a queue-level model of the fetch stage.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int W = 32;
  localparam int A = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_if #(.WORD(W), .ADDR(A)) bus ();

  ifetch #(.WORD(W), .ADDR(A)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [W-1:0] memword(input logic [A-1:0] a);
    return {a ^ 16'h5A5A, a + 16'h1357};
  endfunction

  // Synchronous instruction memory: data one cycle after the request.
  logic [W-1:0] mem_q;
  always @(posedge clk) if (bus.imem_req_o) mem_q <= memword(bus.imem_addr_o);
  assign bus.imem_data_i = mem_q;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue-level model: pending addresses in order, one optional outstanding read, next PC.
  logic [A-1:0] exp_q[$];
  logic         m_infl;
  logic [A-1:0] m_infl_addr;
  logic [A-1:0] m_pc;

  task automatic model_cycle(input logic r, input logic s, input logic b, input logic [A-1:0] ba);
    logic e_v, e_pop, e_req;
    int   occ;
    @(negedge clk);
    rst            = r;
    bus.stall_i    = s;
    bus.br_v_i     = b;
    bus.br_addr_i  = ba;
    #1;
    if (r) begin
      check("rnd rst v", 32'(bus.v_o), 32'd0);
      check("rnd rst req", 32'(bus.imem_req_o), 32'd0);
      check("rnd rst orig", 32'(bus.origaddr_o), 32'd0);
      check("rnd rst inst", bus.inst_o, 32'd0);
      exp_q.delete();
      m_infl = 1'b0;
      m_pc   = '0;
    end else begin
      e_v   = (exp_q.size() != 0);
      e_pop = e_v && !s && !b;
      occ   = exp_q.size() + int'(m_infl) - int'(e_pop);
      e_req = !b && (occ < 2);
      check("rnd v", 32'(bus.v_o), 32'(e_v));
      check("rnd req", 32'(bus.imem_req_o), 32'(e_req));
      if (e_req) check("rnd req addr", 32'(bus.imem_addr_o), 32'(m_pc));
      if (e_v) begin
        check("rnd orig", 32'(bus.origaddr_o), 32'(exp_q[0]));
        check("rnd inst", bus.inst_o, memword(exp_q[0]));
      end
      if (b) begin
        exp_q.delete();
        m_infl = 1'b0;
        m_pc   = ba;
      end else begin
        if (e_pop) void'(exp_q.pop_front());
        if (m_infl) begin
          check("rnd buffer room", 32'(exp_q.size() < 2), 32'd1);
          exp_q.push_back(m_infl_addr);
        end
        m_infl = e_req;
        if (e_req) begin
          m_infl_addr = m_pc;
          m_pc        = m_pc + 16'd1;
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         stall;
    logic         br;
    logic [A-1:0] br_addr;
    logic         req;
    logic [A-1:0] req_addr;
    logic         v;
    logic [A-1:0] orig;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic b, input logic [A-1:0] ba,
                              input logic rq, input logic [A-1:0] ra,
                              input logic v, input logic [A-1:0] o);
    vec_t t;
    t.stall = s; t.br = b; t.br_addr = ba;
    t.req = rq; t.req_addr = ra; t.v = v; t.orig = o;
    return t;
  endfunction

  task automatic drive_check(input string tag, input vec_t t);
    @(negedge clk);
    bus.stall_i   = t.stall;
    bus.br_v_i    = t.br;
    bus.br_addr_i = t.br_addr;
    #1;
    check({tag, " v"}, 32'(bus.v_o), 32'(t.v));
    check({tag, " req"}, 32'(bus.imem_req_o), 32'(t.req));
    if (t.req) check({tag, " req addr"}, 32'(bus.imem_addr_o), 32'(t.req_addr));
    if (t.v) begin
      check({tag, " orig"}, 32'(bus.origaddr_o), 32'(t.orig));
      check({tag, " inst"}, bus.inst_o, memword(t.orig));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.stall_i   = 1'b0;
    bus.br_v_i    = 1'b0;
    bus.br_addr_i = '0;

    // Streaming, 5-cycle stall, redirect to 0x40, redirect+stall to 0x80, wrap past 0xFFFF.
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0003, 1, 16'h0001));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0004, 1, 16'h0002));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0003));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 16'h0007, 1, 16'h0005));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0041, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0042, 1, 16'h0040));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0043, 1, 16'h0041));
    tbl.push_back(mk(1, 1, 16'h0080, 0, 16'h0044, 1, 16'h0042));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h0081, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0082, 1, 16'h0080));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0082, 1, 16'h0080));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0082, 1, 16'h0080));
    tbl.push_back(mk(0, 1, 16'hFFFE, 0, 16'h0083, 1, 16'h0081));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFE));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0001, 1, 16'hFFFF));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000));

    repeat (3) @(negedge clk);
    #1;
    check("reset v", 32'(bus.v_o), 32'd0);
    check("reset inst", bus.inst_o, 32'd0);
    check("reset orig", 32'(bus.origaddr_o), 32'd0);
    check("reset req", 32'(bus.imem_req_o), 32'd0);
    check("reset addr", 32'(bus.imem_addr_o), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("tbl0 v", 32'(bus.v_o), 32'(tbl[0].v));
        check("tbl0 req", 32'(bus.imem_req_o), 32'(tbl[0].req));
        check("tbl0 req addr", 32'(bus.imem_addr_o), 32'(tbl[0].req_addr));
      end else begin
        drive_check($sformatf("tbl%0d", i), tbl[i]);
      end
    end

    // Reset with a read to 0x0002 outstanding: outputs clear at once, old word never shows.
    @(negedge clk);
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.br_v_i  = 1'b0;
    #1;
    check("midrst v", 32'(bus.v_o), 32'd0);
    check("midrst inst", bus.inst_o, 32'd0);
    check("midrst orig", 32'(bus.origaddr_o), 32'd0);
    check("midrst req", 32'(bus.imem_req_o), 32'd0);
    check("midrst addr", 32'(bus.imem_addr_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst req", 32'(bus.imem_req_o), 32'd1);
    check("postrst addr", 32'(bus.imem_addr_o), 32'd0);
    check("postrst v0", 32'(bus.v_o), 32'd0);
    drive_check("postrst1", mk(0, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000));
    drive_check("postrst2", mk(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000));
    drive_check("postrst3", mk(0, 0, 16'h0000, 1, 16'h0003, 1, 16'h0001));

    // Random traffic against the queue model, starting from a reset pulse.
    for (int c = 0; c < 3000; c++) begin
      logic         r_rst, r_stall, r_br;
      logic [A-1:0] r_addr;
      r_rst   = (c == 0) || ($urandom_range(0, 199) == 0);
      r_stall = ($urandom_range(0, 99) < 30);
      r_br    = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) r_addr = 16'hFFFD + 16'($urandom_range(0, 2));
      else                           r_addr = 16'($urandom);
      model_cycle(r_rst, r_stall, r_br, r_addr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
